vdma_out_frame_guard: RTL

- Sits directly downstream of the memory-read video engine, in the video pixel clock domain.
- Consumes its native out_vsync/out_hsync/out_de/odata stream, measures the geometry of every line and frame against vactive/hactive, and repairs it before the display/encoder.
- Repair: over-long lines and surplus lines are clipped; short lines are padded with fill_color.
- Exposes sticky/counted error status for software and debug.

---
 rtl/vdma_guard_pkg.sv | 28 ++
 rtl/vdma_out_frame_guard_if.sv | 16 +
 rtl/vdma_line_meter.sv | 69 ++++++
 rtl/vdma_out_frame_guard.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/vdma_guard_pkg.sv
// Shared types and helpers for the VDMA output frame guard.
//   guard_state_e : guard FSM states (IDLE / ACTIVE / PAD)
//   CNT_W_DEF     : default width of the software-visible counters
//   GEOM_W        : width of the line/pixel geometry counters and limits
//   norm_pol()    : maps a sync input to active-high
//   sat_inc16()   : saturating increment for geometry counters
package vdma_guard_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        PAD    = 2'd2
    } guard_state_e;

    localparam int CNT_W_DEF = 16;
    localparam int GEOM_W    = 16;

    function automatic logic norm_pol(input logic sig, input logic active_low);
        return sig ^ active_low;
    endfunction

    // Geometry counters stick at all-ones so a runaway line/frame never
    // wraps back into the "in range" window.
    function automatic logic [GEOM_W-1:0] sat_inc16(input logic [GEOM_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/vdma_out_frame_guard_if.sv
// Video timing/pixel stream bundle used on both sides of the frame guard.
//   vsync, hsync : sync pulses (polarity set by the guard's SYNC_POL)
//   de           : data enable
//   data         : pixel value
// master drives the stream, slave receives it.
interface vdma_out_frame_guard_if #(
    parameter int DSIZE = 24
);
    logic             vsync;
    logic             hsync;
    logic             de;
    logic [DSIZE-1:0] data;

    modport master (output vsync, hsync, de, data);
    modport slave  (input  vsync, hsync, de, data);
endinterface

// File: rtl/vdma_line_meter.sv
// Line/frame geometry meter for the frame guard.
//   clock, rst_n : pixel clock, async active-low reset
//   vs_act       : vsync, already normalised to active-high
//   de           : input data enable
//   run          : guard is measuring this cycle (counters otherwise hold)
//   pad_inc      : a pad pixel is emitted this cycle (advances pix_cnt)
//   frame_start  : inactive->active vsync edge (combinational pulse)
//   line_end     : falling de, or frame start while a line is open
//   new_line     : first pixel of a line (de rise) or frame start
//   pix_cnt      : pixels (incl. pad) seen on the current/last line
//   line_cnt     : completed lines in the current frame
//   eff_pix      : pixel index of the current-cycle pixel
//   eff_line     : line index of the current-cycle pixel
module vdma_line_meter
    import vdma_guard_pkg::*;
(
    input  logic              clock,
    input  logic              rst_n,
    input  logic              vs_act,
    input  logic              de,
    input  logic              run,
    input  logic              pad_inc,
    output logic              frame_start,
    output logic              line_end,
    output logic              new_line,
    output logic [GEOM_W-1:0] pix_cnt,
    output logic [GEOM_W-1:0] line_cnt,
    output logic [GEOM_W-1:0] eff_pix,
    output logic [GEOM_W-1:0] eff_line
);

    logic vs_q;
    logic de_q;

    assign frame_start = vs_act & ~vs_q;
    assign line_end    = de_q & (~de | frame_start);
    assign new_line    = (de & ~de_q) | frame_start;

    // Counters are cleared lazily: the current cycle already sees index 0
    // on a new line / new frame, the register catches up on the edge.
    assign eff_pix  = new_line    ? '0 : pix_cnt;
    assign eff_line = frame_start ? '0 : line_cnt;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            vs_q     <= 1'b0;
            de_q     <= 1'b0;
            pix_cnt  <= '0;
            line_cnt <= '0;
        end else begin
            vs_q <= vs_act;
            de_q <= de;
            if (run) begin
                if (frame_start)
                    line_cnt <= '0;
                else if (line_end)
                    line_cnt <= sat_inc16(line_cnt);

                // After a line ends pix_cnt keeps the line length, which is
                // where padding resumes counting from.
                if (de || pad_inc)
                    pix_cnt <= sat_inc16(eff_pix);
                else if (frame_start)
                    pix_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/vdma_out_frame_guard.sv
// Output frame guard: measures every line and frame of the read engine's
// video stream against hactive/vactive and repairs it with 1 cycle latency.
// Over-long lines and surplus lines are blanked, short lines are padded
// with fill_color. Status counters expose the damage to software.
//   clock, rst_n          : pixel clock, async active-low reset
//   enable                : guard on; sampled at frame start only
//   vactive, hactive      : expected geometry (0 disables that dimension)
//   fill_color            : pad pixel value
//   vid_in  (slave)       : stream from the memory-read engine
//   vid_out (master)      : repaired stream
//   frame_ok              : last completed frame was clean
//   line_err_cnt          : bad-length lines (saturating)
//   frame_err_cnt         : bad-line-count frames (saturating)
//   frame_cnt             : completed frames (wrapping)
module vdma_out_frame_guard
    import vdma_guard_pkg::*;
#(
    parameter int    DSIZE    = 24,
    parameter string SYNC_POL = "HIGH",
    parameter int    CNT_W    = CNT_W_DEF
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [GEOM_W-1:0]     vactive,
    input  logic [GEOM_W-1:0]     hactive,
    input  logic [DSIZE-1:0]      fill_color,
    vdma_out_frame_guard_if.slave  vid_in,
    vdma_out_frame_guard_if.master vid_out,
    output logic                  frame_ok,
    output logic [CNT_W-1:0]      line_err_cnt,
    output logic [CNT_W-1:0]      frame_err_cnt,
    output logic [CNT_W-1:0]      frame_cnt
);

    localparam logic POL_LOW = (SYNC_POL == "LOW");

    guard_state_e state;

    logic              vs_act;
    logic              frame_start;
    logic              line_end;
    logic              new_line;
    logic [GEOM_W-1:0] pix_cnt;
    logic [GEOM_W-1:0] line_cnt;
    logic [GEOM_W-1:0] eff_pix;
    logic [GEOM_W-1:0] eff_line;

    logic              h_on;
    logic              v_on;
    logic              guarding;
    logic              run;
    logic              closing;
    logic              line_done;
    logic              line_bad;
    logic              line_clip;
    logic              pix_ok;
    logic              start_pad;
    logic              pad_cont;
    logic              pad_inc;
    logic              pad_last;
    logic [GEOM_W-1:0] lines_final;
    logic              frame_bad;
    logic              err_flag;

    assign vs_act = norm_pol(vid_in.vsync, POL_LOW);

    vdma_line_meter u_meter (
        .clock       (clock),
        .rst_n       (rst_n),
        .vs_act      (vs_act),
        .de          (vid_in.de),
        .run         (run),
        .pad_inc     (pad_inc),
        .frame_start (frame_start),
        .line_end    (line_end),
        .new_line    (new_line),
        .pix_cnt     (pix_cnt),
        .line_cnt    (line_cnt),
        .eff_pix     (eff_pix),
        .eff_line    (eff_line)
    );

    assign h_on     = |hactive;
    assign v_on     = |vactive;
    assign guarding = (state != IDLE);
    // The frame-start cycle that leaves IDLE is already treated as guarded.
    assign run      = guarding | (frame_start & enable);
    assign closing  = guarding & frame_start;
    assign line_done = guarding & line_end;
    assign line_bad  = line_done & h_on & (pix_cnt != hactive);

    assign line_clip = v_on & (eff_line >= vactive);
    assign pix_ok    = ~line_clip & (~h_on | (eff_pix < hactive));

    // Padding starts in the cycle the line ends so the pad pixels follow
    // the real ones back-to-back. A frame start closes the line unpadded,
    // and lines already beyond vactive are never padded.
    assign start_pad = line_done & ~frame_start & h_on & (pix_cnt < hactive)
                     & ~(v_on & (line_cnt >= vactive));
    assign pad_cont  = (state == PAD) & ~new_line;
    assign pad_inc   = start_pad | pad_cont;
    assign pad_last  = (sat_inc16(pix_cnt) >= hactive);

    // A line still open at frame start belongs to the frame being closed.
    assign lines_final = line_done ? sat_inc16(line_cnt) : line_cnt;
    assign frame_bad   = v_on & (lines_final != vactive);

    // FSM and registered video outputs
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            vid_out.vsync <= POL_LOW;
            vid_out.hsync <= POL_LOW;
            vid_out.de    <= 1'b0;
            vid_out.data  <= '0;
        end else begin
            vid_out.vsync <= vid_in.vsync;
            vid_out.hsync <= vid_in.hsync;

            if (!run) begin
                vid_out.de   <= vid_in.de;
                vid_out.data <= vid_in.data;
            end else if (pad_inc) begin
                vid_out.de   <= 1'b1;
                vid_out.data <= fill_color;
            end else if (vid_in.de && !pix_ok) begin
                vid_out.de   <= 1'b0;
                vid_out.data <= '0;
            end else begin
                vid_out.de   <= vid_in.de;
                vid_out.data <= vid_in.data;
            end

            case (state)
                IDLE: begin
                    if (frame_start && enable)
                        state <= ACTIVE;
                end
                default: begin
                    if (frame_start)
                        state <= enable ? ACTIVE : IDLE;
                    else if (pad_inc)
                        state <= pad_last ? ACTIVE : PAD;
                    else
                        state <= ACTIVE;   // also the de-rise abort out of PAD
                end
            endcase
        end
    end

    // Status counters; nothing moves while IDLE.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            frame_ok      <= 1'b0;
            line_err_cnt  <= '0;
            frame_err_cnt <= '0;
            frame_cnt     <= '0;
            err_flag      <= 1'b0;
        end else begin
            if (line_bad && !(&line_err_cnt))
                line_err_cnt <= line_err_cnt + 1'b1;

            if (closing) begin
                frame_ok  <= ~(err_flag | line_bad | frame_bad);
                frame_cnt <= frame_cnt + 1'b1;
                if (frame_bad && !(&frame_err_cnt))
                    frame_err_cnt <= frame_err_cnt + 1'b1;
                err_flag  <= 1'b0;
            end else if (line_bad) begin
                err_flag  <= 1'b1;
            end
        end
    end

endmodule
